// File: rtl/eq_gain_ctrl.sv
// Equalizer gain controller: captures the eq_spi word on frame end, validates it and
// slews six 4-bit band gains toward their targets. Define EQ_RAMP_EN for per-tick slewing.
//
// state   | meaning
// IDLE    | waiting for a frame end
// CAPTURE | word held; accept/reject decision taken on exit
// CHECK   | upd_pulse cycle; resume RAMP if gains still differ from targets
// RAMP    | step every differing band by one per tick (EQ_RAMP_EN only)
module eq_gain_ctrl #(
    parameter logic [3:0] UNITY  = 4'd8,
    parameter int         NBANDS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [31:0] eq_word,
    input  logic        tick,
    output logic [23:0] gains,
    output logic        ramping,
    output logic        upd_pulse,
    output logic [7:0]  err_count
);

`ifdef EQ_RAMP_EN
    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, RAMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, CHECK} state_t;
`endif

    state_t      state, state_next;
    logic        sync1, sync2;
    logic        frame_end;
    logic        cap_en, chk_en, step_en;
    logic [31:0] word_q;
    logic [23:0] target_q, target_next, new_target, gains_next;
    logic [3:0]  csum;
    logic        accept;

    // sync1 is the newest synchronized sample, sync2 the one before it
    assign frame_end = sync2 & ~sync1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
        end else begin
            sync1 <= ce;
            sync2 <= sync1;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        chk_en     = 1'b0;
        step_en    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    cap_en     = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                chk_en     = 1'b1;
                state_next = CHECK;
            end
`ifdef EQ_RAMP_EN
            CHECK: state_next = ramping ? RAMP : IDLE;
            RAMP: begin
                if (frame_end) begin
                    cap_en     = 1'b1;
                    state_next = CAPTURE;
                end else begin
                    step_en = tick;
                    if (!ramping) state_next = IDLE;
                end
            end
`else
            CHECK: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        csum = 4'h0;
        for (int k = 0; k < NBANDS; k++) csum = csum ^ word_q[4*k +: 4];
    end

    assign accept      = ((word_q[31:28] == 4'hE) && (csum == word_q[27:24])) ||
                         (word_q[31:28] == 4'h0);
    assign new_target  = (word_q[31:28] == 4'h0) ? {NBANDS{UNITY}} : word_q[23:0];
    assign target_next = (chk_en && accept) ? new_target : target_q;

`ifdef EQ_RAMP_EN
    always_comb begin
        gains_next = gains;
        if (step_en) begin
            for (int k = 0; k < NBANDS; k++) begin
                if (gains[4*k +: 4] < target_q[4*k +: 4])
                    gains_next[4*k +: 4] = gains[4*k +: 4] + 4'd1;
                else if (gains[4*k +: 4] > target_q[4*k +: 4])
                    gains_next[4*k +: 4] = gains[4*k +: 4] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ramping <= 1'b0;
        else       ramping <= (gains_next != target_next);
    end
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign gains_next  = target_next;
    assign ramping     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= 32'h0;
            target_q  <= {NBANDS{UNITY}};
            gains     <= {NBANDS{UNITY}};
            upd_pulse <= 1'b0;
            err_count <= 8'h00;
        end else begin
            upd_pulse <= 1'b0;
            if (cap_en) word_q <= eq_word;
            if (chk_en) begin
                if (accept)                  upd_pulse <= 1'b1;
                else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            target_q <= target_next;
            gains    <= gains_next;
        end
    end

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Self-checking bench for eq_gain_ctrl: directed scenarios plus randomized frames and
// ticks compared against a band-level gain/target model.
module tb_eq_gain_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [31:0] eq_word;
    logic        tick;
    logic [23:0] gains;
    logic        ramping;
    logic        upd_pulse;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    int mg [6];
    int mt [6];
    int merr;
    bit macc;

    eq_gain_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .eq_word   (eq_word),
        .tick      (tick),
        .gains     (gains),
        .ramping   (ramping),
        .upd_pulse (upd_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack(input int v [6]);
        logic [23:0] r = 24'h0;
        for (int k = 0; k < 6; k++) r[4*k +: 4] = v[k][3:0];
        return r;
    endfunction

    function automatic logic model_ramping();
`ifdef EQ_RAMP_EN
        for (int k = 0; k < 6; k++) if (mg[k] != mt[k]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            mg[k] = 8;
            mt[k] = 8;
        end
        merr = 0;
    endtask

    task automatic model_frame(input logic [31:0] w);
        int x = 0;
        int cmd = int'(w[31:28]);
        for (int k = 0; k < 6; k++) x = x ^ int'(w[4*k +: 4]);
        macc = 1'b1;
        if (cmd == 14 && x == int'(w[27:24]))
            for (int k = 0; k < 6; k++) mt[k] = int'(w[4*k +: 4]);
        else if (cmd == 0)
            for (int k = 0; k < 6; k++) mt[k] = 8;
        else begin
            macc = 1'b0;
            if (merr < 255) merr++;
        end
`ifndef EQ_RAMP_EN
        for (int k = 0; k < 6; k++) mg[k] = mt[k];
`endif
    endtask

    task automatic model_tick();
`ifdef EQ_RAMP_EN
        for (int k = 0; k < 6; k++) begin
            if (mg[k] < mt[k])      mg[k]++;
            else if (mg[k] > mt[k]) mg[k]--;
        end
`endif
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gains"}, {8'h0, gains}, {8'h0, pack(mg)});
        chk({tag, ".ramping"}, {31'h0, ramping}, {31'h0, model_ramping()});
        chk({tag, ".err"}, {24'h0, err_count}, merr);
    endtask

    // ticks offered from frame-end onward through CHECK must all be dropped
    task automatic send_frame(input logic [31:0] w, input logic pause_tick);
        logic [23:0] g_before;
        eq_word = w;
        ce = 1'b1;
        repeat (3) cyc();
        ce = 1'b0;
        cyc();
        tick = pause_tick;
        g_before = pack(mg);
        cyc();
        chk("frame.n1_gains", {8'h0, gains}, {8'h0, g_before});
        cyc();
        model_frame(w);
        chk("frame.upd_n2", {31'h0, upd_pulse}, {31'h0, macc});
        check_all("frame.n2");
        cyc();
        tick = 1'b0;
        chk("frame.upd_n3", {31'h0, upd_pulse}, 32'h0);
        check_all("frame.n3");
    endtask

    task automatic do_tick(input string tag);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        model_tick();
        check_all(tag);
        chk({tag, ".upd"}, {31'h0, upd_pulse}, 32'h0);
    endtask

    function automatic logic [31:0] valid_word(input logic [23:0] t);
        logic [3:0] x = 4'h0;
        for (int k = 0; k < 6; k++) x = x ^ t[4*k +: 4];
        return {4'hE, x, t};
    endfunction

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        tick = 1'b0;
        eq_word = 32'h0;
        model_reset();
        repeat (3) cyc();
        reset = 1'b0;
        repeat (4) cyc();
        check_all("reset");
        chk("reset.gains_const", {8'h0, gains}, 32'h00888888);
        chk("reset.upd", {31'h0, upd_pulse}, 32'h0);

        send_frame(32'hEC9A7888, 1'b0);
        do_tick("valid.t1");
`ifdef EQ_RAMP_EN
        chk("valid.t1_const", {8'h0, gains}, 32'h00997888);
`else
        chk("valid.direct_const", {8'h0, gains}, 32'h009A7888);
`endif
        do_tick("valid.t2");
        chk("valid.t2_const", {8'h0, gains}, 32'h009A7888);
        chk("valid.t2_ramp", {31'h0, ramping}, 32'h0);

        send_frame(32'hE09A7888, 1'b1);
        chk("badsum.err_const", {24'h0, err_count}, 32'h1);
        send_frame(32'h5C9A7888, 1'b0);
        chk("badcmd.err_const", {24'h0, err_count}, 32'h2);

        // unity command mid-ramp, with ticks offered during the frame pause
        send_frame(32'h00000000, 1'b0);
        send_frame(32'hEC9A7888, 1'b0);
        do_tick("mid.t1");
        send_frame(32'h00000000, 1'b1);
        do_tick("unity.t1");
        do_tick("unity.t2");
        chk("unity.const", {8'h0, gains}, 32'h00888888);

        // reset during a ramp
        send_frame(32'hE0F00000 | valid_word(24'hF00000), 1'b0);
        do_tick("rst.t1");
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst.async");
        chk("rst.upd", {31'h0, upd_pulse}, 32'h0);
        cyc();
        reset = 1'b0;
        cyc();
        send_frame(32'hEC9A7888, 1'b0);
        do_tick("post_rst.t1");
        do_tick("post_rst.t2");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            int kind = $urandom_range(0, 3);
            case (kind)
                0: w = valid_word(24'($urandom));
                1: w = {8'h00, 24'($urandom)};
                2: begin
                    w = valid_word(24'($urandom));
                    w[27:24] = w[27:24] ^ 4'($urandom_range(1, 15));
                end
                default: w = $urandom;
            endcase
            send_frame(w, 1'($urandom_range(0, 1)));
            for (int t = $urandom_range(0, 16); t > 0; t--) begin
                repeat ($urandom_range(0, 2)) cyc();
                do_tick("rand.tick");
            end
        end

        for (int i = 0; i < 256; i++) send_frame(32'h5C9A7888 ^ {4'h0, 28'($urandom)}, 1'b0);
        chk("sat.const", {24'h0, err_count}, 32'hFF);
        send_frame(32'hE09A7888, 1'b0);
        chk("sat.hold", {24'h0, err_count}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eq_gain_ctrl.md
# eq_gain_ctrl

Clock-domain receiver and gain controller that sits directly downstream of the `eq_spi` equalizer-settings receiver. It detects the end of each SPI frame from `ce` and captures the 32-bit `eqVals` word into the system clock domain. It validates the command and checksum, then drives six 4-bit band gains to the audio path. Gains slew one step per sample tick to avoid zipper noise.

## Interface
- Parameters:
  - `UNITY`, 4'd8: reset / unity gain code per band
  - `NBANDS`, 6: number of bands (fixed by word format; not meant to be overridden)
- Ports:
  - `clk` in 1: system clock (HSOSC)
  - `reset` in 1: asynchronous, active-high reset
  - `ce` in 1: SPI frame-active, asynchronous to `clk`; high during transfer
  - `eq_word` in 32: shifted word from `eq_spi`; stable while `ce` low
  - `tick` in 1: one-cycle audio sample strobe
  - `gains` out 24: current gains; band k = `gains[4k+3:4k]`
  - `ramping` out 1: high while any gain differs from its target
  - `upd_pulse` out 1: one-cycle pulse on accepted frame
  - `err_count` out 8: saturating count of rejected frames

## Operation
- Word format:
  - `[31:28]` cmd
  - `[27:24]` checksum, equal to the XOR of the six nibbles `[23:20]`…`[3:0]`
  - band k target = `eq_word[4k+3:4k]`
- Commands:
  - cmd 4'hE with a valid checksum loads all six targets.
  - cmd 4'h0 sets all targets to `UNITY`; the checksum is ignored.
  - Anything else, or 4'hE with a bad checksum, is rejected. `err_count` increments and saturates at 8'hFF. Targets are unchanged.
- `ce` passes through a 2-flop synchronizer, both flops reset to 0. A frame end is the falling edge of the synchronized `ce` (previous 1, current 0).
- FSM states are IDLE, CAPTURE, CHECK, RAMP.
  - IDLE: on frame end, go to CAPTURE.
  - CAPTURE: register `eq_word` into the internal word register, then go to CHECK.
  - CHECK, accepted: update targets and pulse `upd_pulse`. Go to RAMP if any new target differs from its current gain, else IDLE.
  - CHECK, rejected: increment `err_count` and return to the state held before CAPTURE. That state is RAMP if `ramping` was high, else IDLE.
  - RAMP: on each `tick`, move every band with gain ≠ target by ±1 toward its target. When all bands are equal, go to IDLE.
  - Frame end during RAMP: go to CAPTURE. The frame end has priority over a coincident `tick`, which is dropped.
- Ticks are acted on only in RAMP. While in CAPTURE or CHECK, ticks are dropped, so the ramp pauses for 2 cycles.
- New targets accepted mid-ramp replace the old ones; the ramp continues from the present gains.
- Gains are unsigned 0..15; steps never wrap.

## Timing
- Reset values:
  - `gains` = 24'h888888, targets = `UNITY`
  - `ramping` = 0, `upd_pulse` = 0, `err_count` = 0
  - synchronizer = 0, state = IDLE
- Frame latency: let edge N be the first `clk` edge at which sync1 samples `ce` low.
  - Edge N+1: frame end detected (combinational); word captured at this edge.
  - Edge N+2: CHECK decision; targets and `err_count` update; `upd_pulse` is high for the cycle after N+2.
- `ramping` is registered. It goes high at edge N+2 if any target differs from its gain. It goes low at the edge where the last gain reaches its target, in the same cycle that gain updates.
- Maximum ramp length is 15 ticks.
- Reset asserted mid-frame or mid-ramp returns everything immediately to reset values; a partially captured frame is discarded.
- `ce` pulses shorter than 2 `clk` periods may be missed. This is acceptable; `eq_spi` frames span 32 SCK cycles.

## Configuration
- `EQ_RAMP_EN` defined: slewing behaves as described above.
- `EQ_RAMP_EN` undefined:
  - RAMP state is removed.
  - `gains` loads the targets at edge N+2.
  - `ramping` is tied to 0.
  - `tick` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset release, no activity: `gains`=24'h888888, `ramping`=0, `err_count`=0, no `upd_pulse`.
- Valid frame `eq_word`=32'hEC9A7888, `ce` 1→0:
  - `upd_pulse` at N+2; `ramping` high.
  - After tick 1, `gains`=24'h997888.
  - After tick 2, `gains`=24'h9A7888 and `ramping` falls.
  - Without `EQ_RAMP_EN`, `gains`=24'h9A7888 directly at N+2.
- Bad checksum 32'hE09A7888: `err_count`=1, no `upd_pulse`, `gains` unchanged. Unknown cmd 32'h5C9A7888: `err_count`=2.
- During the ramp from the valid-frame scenario (after 1 tick), send 32'h00000000: targets become unity. Subsequent ticks return `gains` to 24'h888888. Ticks coincident with the frame end or with CAPTURE/CHECK cause no step.
- 256 rejected frames: `err_count` saturates at 8'hFF.
- Assert `reset` mid-ramp: outputs return to reset values on the same edge. The next valid frame works normally.
